mult_div_unit: RTL and testbench
================================

# mult_div_unit

Parametrised multi-cycle multiply/divide unit that owns the HI/LO register pair for the MIPS core. Replaces the single-cycle 64-bit ALU product with an iterative shift-add multiplier and restoring divider sharing one datapath, with a start/busy/done handshake to the controller. Supports signed and unsigned MULT/DIV plus direct HI/LO writes (MTHI/MTLO).

## Interface

- WIDTH, 32: operand width; HI and LO are WIDTH bits each; must be ≥ 4.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request an operation; accepted only when busy=0.
- op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- a  input  WIDTH  multiplicand / dividend (sampled on accept).
- b  input  WIDTH  multiplier / divisor (sampled on accept).
- hi_we  input  1  MTHI: write wdata into hi.
- lo_we  input  1  MTLO: write wdata into lo.
- wdata  input  WIDTH  MTHI/MTLO data.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse: hi/lo just updated by an operation.
- div_by_zero  output  1  valid with done; divisor was zero.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

## Operation

- Reset values: hi=0, lo=0, busy=0, done=0, div_by_zero=0, state IDLE.
- States: IDLE → RUN → FIX → IDLE. busy = (state ≠ IDLE).
- IDLE, start=1: latch op, |a|, |b| (absolute values only for signed ops), record result signs; clear accumulator; iteration count=0; go RUN.
- RUN: one iteration per cycle (multiply: conditional add then shift right of {acc, multiplier}; divide: shift left of {rem, quotient}, trial subtract, restore if negative). After WIDTH iterations go FIX.
- FIX: apply sign correction, write hi/lo, assert done next cycle, go IDLE.
- Multiply: {hi, lo} = full 2·WIDTH-bit product (signed or unsigned).
- Divide: lo = quotient, hi = remainder; signed quotient truncates toward zero, remainder takes the dividend's sign.
- Divide by zero: lo = all ones, hi = a (unchanged dividend), div_by_zero=1 with done. Runs full latency.
- Signed overflow (a = most negative, b = −1): lo = most negative, hi = 0, div_by_zero=0.
- start while busy: ignored, no queueing.
- hi_we/lo_we while busy: ignored. While IDLE: register written on next edge. Simultaneous start and hi_we/lo_we in IDLE: write takes effect, operation is accepted, result later overwrites.
- reset mid-operation: immediately returns to IDLE, all outputs to reset values; no done.

## Timing

- Accept edge = edge 1. RUN occupies edges 2..WIDTH+1; FIX at edge WIDTH+2.
- hi/lo updated and done=1 in the cycle after edge WIDTH+2 (WIDTH=32: 34 edges).
- busy high from after edge 1 through edge WIDTH+2; low in the done cycle.
- A new start is accepted in the done cycle (back-to-back throughput WIDTH+2 cycles).
- hi/lo hold their values throughout an operation until the FIX edge.

## Configuration

- MDU_SIGNED_EN defined: op[0] selects signed MULT/DIV, sign correction in FIX, signed-overflow rule active.
- Not defined: op[0] ignored, all operations unsigned, no absolute-value/negation logic; FIX state retained so latency is identical.

## Test plan

- WIDTH=32, MULTU a=0xFFFFFFFF b=0xFFFFFFFF → after 34 edges done=1, hi=0xFFFFFFFE, lo=0x00000001; busy low in done cycle.
- MULT a=−3 b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1; without MDU_SIGNED_EN → hi=0x00000004, lo=0xFFFFFFF1.
- DIV a=−7 b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV a=0x80000000 b=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=100 b=0 → lo=0xFFFFFFFF, hi=0x00000064, div_by_zero=1 with done.
- Start MULTU 6×7, pulse start with different operands at edge 5 and lo_we at edge 8 → both ignored; result hi=0, lo=42; then MTHI 0x1234 while idle → hi=0x1234 next edge.
- Start DIVU, assert reset at edge 10 → busy=0, hi=lo=0, no done pulse; fresh start after release completes normally.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// Controller-side bundle for mult_div_unit: operation handshake, MTHI/MTLO writes, HI/LO readback.
interface mult_div_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, hi_we, lo_we, wdata,
                  input  busy, done, div_by_zero, hi, lo);
  modport slave  (input  start, op, a, b, hi_we, lo_we, wdata,
                  output busy, done, div_by_zero, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider owning HI/LO (IDLE -> RUN x WIDTH -> FIX).
// Define MDU_SIGNED_EN to enable signed MULT/DIV (op[0]); otherwise everything is unsigned.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            reset,
  mult_div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             b_zero_q, b_zero_d;
  logic [WIDTH-1:0] acc_q, acc_d;   // product high half / partial remainder
  logic [WIDTH-1:0] mq_q, mq_d;     // multiplier / quotient
  logic [WIDTH-1:0] bv_q, bv_d;     // multiplicand / divisor magnitude
  logic [WIDTH-1:0] a_q, a_d;       // raw dividend, returned in HI on divide-by-zero
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
`ifdef MDU_SIGNED_EN
  logic             res_neg_q, res_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             sgn;
`endif

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     sum, add_v, rem_sh, trial;
  logic [2*WIDTH-1:0] prod;

  assign sum    = {1'b0, acc_q} + {1'b0, bv_q};
  assign add_v  = mq_q[0] ? sum : {1'b0, acc_q};
  assign rem_sh = {acc_q, mq_q[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, bv_q};
  assign prod   = {acc_q, mq_q};

`ifdef MDU_SIGNED_EN
  assign sgn   = bus.op[0];
  assign a_mag = (sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag = (sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
`else
  assign a_mag = bus.a;
  assign b_mag = bus.b;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    b_zero_d = b_zero_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    bv_d     = bv_q;
    a_d      = a_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;
`ifdef MDU_SIGNED_EN
    res_neg_d = res_neg_q;
    rem_neg_d = rem_neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.hi_we) hi_d = bus.wdata;
        if (bus.lo_we) lo_d = bus.wdata;
        if (bus.start) begin
          state_d  = RUN;
          cnt_d    = '0;
          is_div_d = bus.op[1];
          b_zero_d = (bus.b == '0);
          acc_d    = '0;
          mq_d     = a_mag;
          bv_d     = b_mag;
          a_d      = bus.a;
`ifdef MDU_SIGNED_EN
          res_neg_d = sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          rem_neg_d = sgn & bus.a[WIDTH-1];
`endif
        end
      end
      RUN: begin
        if (is_div_q) begin
          // Restoring step: keep the shifted remainder when the trial borrows.
          if (trial[WIDTH]) begin
            acc_d = rem_sh[WIDTH-1:0];
            mq_d  = {mq_q[WIDTH-2:0], 1'b0};
          end else begin
            acc_d = trial[WIDTH-1:0];
            mq_d  = {mq_q[WIDTH-2:0], 1'b1};
          end
        end else begin
          acc_d = add_v[WIDTH:1];
          mq_d  = {add_v[0], mq_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        dbz_d   = is_div_q & b_zero_q;
        if (is_div_q && b_zero_q) begin
          hi_d = a_q;
          lo_d = '1;
        end else if (is_div_q) begin
`ifdef MDU_SIGNED_EN
          hi_d = rem_neg_q ? -acc_q : acc_q;
          lo_d = res_neg_q ? -mq_q : mq_q;
`else
          hi_d = acc_q;
          lo_d = mq_q;
`endif
        end else begin
`ifdef MDU_SIGNED_EN
          {hi_d, lo_d} = res_neg_q ? -prod : prod;
`else
          {hi_d, lo_d} = prod;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      b_zero_q <= 1'b0;
      acc_q    <= '0;
      mq_q     <= '0;
      bv_q     <= '0;
      a_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
`ifdef MDU_SIGNED_EN
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      b_zero_q <= b_zero_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      bv_q     <= bv_d;
      a_q      <= a_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
`ifdef MDU_SIGNED_EN
      res_neg_q <= res_neg_d;
      rem_neg_q <= rem_neg_d;
`endif
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit (WIDTH=32): directed table, corner sequences, random vs model.
module tb_mult_div_unit;
  localparam int W   = 32;
  localparam int LAT = W + 2;
`ifdef MDU_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(W)) ifc ();
  mult_div_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(ifc));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dbz;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: {dbz, hi, lo} from plain arithmetic on the operation definition.
  function automatic logic [64:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic        s;
    longint      sp;
    logic [63:0] up;
    int          q, r;
    s = SGN && op[0];
    if (!op[1]) begin
      if (s) begin
        sp = longint'(int'(a)) * longint'(int'(b));
        return {1'b0, 64'(sp)};
      end
      up = {32'd0, a} * {32'd0, b};
      return {1'b0, up};
    end
    if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
      q = int'(a) / int'(b);
      r = int'(a) % int'(b);
      return {1'b0, 32'(r), 32'(q)};
    end
    return {1'b0, a % b, a / b};
  endfunction

  // Starts an op from the current (idle/done) cycle and waits, bounded, for done.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
    int lat;
    ifc.start = 1'b1; ifc.op = op; ifc.a = a; ifc.b = b;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    lat = 1;
    chk("busy_after_accept", 64'(ifc.busy), 64'd1);
    while (!ifc.done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(LAT));
    chk("busy_in_done_cycle", 64'(ifc.busy), 64'd0);
    hi = ifc.hi; lo = ifc.lo; dbz = ifc.div_by_zero;
  endtask

  initial begin
    vec_t        vecs[8];
    logic [31:0] hi, lo;
    logic        dbz;
    logic [64:0] exp;
    int          lat;
    bit          saw_done;

    ifc.start = 0; ifc.op = 0; ifc.a = 0; ifc.b = 0;
    ifc.hi_we = 0; ifc.lo_we = 0; ifc.wdata = 0;

    vecs[0] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1] = SGN ? '{2'b01, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0}
                  : '{2'b01, 32'hFFFF_FFFD, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1, 1'b0};
    vecs[2] = SGN ? '{2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0}
                  : '{2'b11, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0};
    vecs[3] = SGN ? '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0}
                  : '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0};
    vecs[4] = '{2'b10, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
    vecs[5] = '{2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0};
    vecs[6] = '{2'b11, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1};
    vecs[7] = '{2'b00, 32'd0, 32'h1234_5678, 32'd0, 32'd0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(ifc.busy), 64'd0);
    chk("reset_done", 64'(ifc.done), 64'd0);
    chk("reset_dbz", 64'(ifc.div_by_zero), 64'd0);
    chk("reset_hi", 64'(ifc.hi), 64'd0);
    chk("reset_lo", 64'(ifc.lo), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Table: consecutive ops start in the done cycle (back-to-back).
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, hi, lo, dbz);
      chk($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].hi));
      chk($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].lo));
      chk($sformatf("vec%0d_dbz", i), 64'(dbz), 64'(vecs[i].dbz));
    end
    @(posedge clk); #1;
    chk("done_single_pulse", 64'(ifc.done), 64'd0);

    // MULTU 6x7 with a stray start at edge 5 and lo_we at edge 8.
    ifc.start = 1; ifc.op = 2'b00; ifc.a = 32'd6; ifc.b = 32'd7;
    @(posedge clk); #1;
    ifc.start = 0;
    lat = 1;
    for (int e = 2; e <= 8; e++) begin
      ifc.start = (e == 5); ifc.a = (e == 5) ? 32'd1000 : 32'd6; ifc.b = (e == 5) ? 32'd1000 : 32'd7;
      ifc.lo_we = (e == 8); ifc.wdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      lat = e;
    end
    ifc.start = 0; ifc.lo_we = 0;
    chk("hold_lo_midop", 64'(ifc.lo), 64'(vecs[7].lo));
    while (!ifc.done && lat < 60) begin @(posedge clk); #1; lat++; end
    chk("ign_latency", 64'(lat), 64'(LAT));
    chk("ign_hi", 64'(ifc.hi), 64'd0);
    chk("ign_lo", 64'(ifc.lo), 64'd42);
    @(posedge clk); #1;
    chk("no_queued_start", 64'(ifc.busy), 64'd0);
    ifc.hi_we = 1; ifc.wdata = 32'h1234;
    @(posedge clk); #1;
    ifc.hi_we = 0;
    chk("mthi_hi", 64'(ifc.hi), 64'h1234);
    chk("mthi_lo_kept", 64'(ifc.lo), 64'd42);

    // Reset in the middle of a DIVU.
    ifc.start = 1; ifc.op = 2'b10; ifc.a = 32'd999; ifc.b = 32'd3;
    @(posedge clk); #1;
    ifc.start = 0;
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_busy", 64'(ifc.busy), 64'd0);
    chk("rst_mid_hi", 64'(ifc.hi), 64'd0);
    chk("rst_mid_lo", 64'(ifc.lo), 64'd0);
    reset = 1'b0;
    saw_done = 0;
    repeat (40) begin @(posedge clk); #1; if (ifc.done) saw_done = 1; end
    chk("rst_mid_no_done", 64'(saw_done), 64'd0);
    run_op(2'b10, 32'd999, 32'd3, hi, lo, dbz);
    chk("post_rst_lo", 64'(lo), 64'd333);
    chk("post_rst_hi", 64'(hi), 64'd0);

    // MTHI together with start: write lands first, result overwrites later.
    ifc.hi_we = 1; ifc.wdata = 32'hABCD;
    ifc.start = 1; ifc.op = 2'b00; ifc.a = 32'd3; ifc.b = 32'd4;
    @(posedge clk); #1;
    ifc.hi_we = 0; ifc.start = 0;
    chk("simul_we_hi", 64'(ifc.hi), 64'hABCD);
    chk("simul_busy", 64'(ifc.busy), 64'd1);
    lat = 1;
    while (!ifc.done && lat < 60) begin @(posedge clk); #1; lat++; end
    chk("simul_latency", 64'(lat), 64'(LAT));
    chk("simul_hi", 64'(ifc.hi), 64'd0);
    chk("simul_lo", 64'(ifc.lo), 64'd12);

    // Random operations against the model.
    for (int i = 0; i < 60; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        default: b = 32'($urandom);
      endcase
      exp = ref_model(op, a, b);
      run_op(op, a, b, hi, lo, dbz);
      chk($sformatf("rnd%0d_op%0d_%h_%h_hi", i, op, a, b), 64'(hi), 64'(exp[63:32]));
      chk($sformatf("rnd%0d_op%0d_%h_%h_lo", i, op, a, b), 64'(lo), 64'(exp[31:0]));
      chk($sformatf("rnd%0d_dbz", i), 64'(dbz), 64'(exp[64]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
